mem_req_unit: RTL and testbench

MEM_REQ_UNIT -- requirements
Module: mem_req_unit

---
 rtl/mem_req_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_req_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_unit.sv
// mem_req_unit: load/store request unit between the pipeline and a simple
// handshaked data-memory bus. Checks alignment, drives word-aligned bus
// requests with byte enables and lane-replicated store data, and extracts and
// extends the selected lane of load data.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that waits
// TIMEOUT_CYCLES cycles without bus_ack (mem_exc = 3).
module mem_req_unit #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [1:0]  mem_width,
   input  logic        mem_sign,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_stall,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   output logic [1:0]  mem_exc,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] EXC_NONE     = 2'd0;
   localparam logic [1:0] EXC_LD_ALIGN = 2'd1;
   localparam logic [1:0] EXC_ST_ALIGN = 2'd2;

   state_t      r_state;
   logic [1:0]  r_width;
   logic        r_sign;
   logic [1:0]  r_lane;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [3:0]  r_bus_be;
   logic [31:0] r_bus_wdata;
   logic        r_mem_done;
   logic [31:0] r_mem_rdata;
   logic [1:0]  r_mem_exc;

   logic        w_misaligned;
   logic [3:0]  w_be_in;
   logic [31:0] w_wdata_in;
   logic [31:0] w_shifted;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_tmo_cnt;
`endif

   // Alignment check, byte enables and lane replication for the incoming request.
   always_comb begin
      w_misaligned = 1'b0;
      w_be_in      = 4'b0000;
      w_wdata_in   = 32'd0;
      case (mem_width)
         2'd0: begin
            w_misaligned = (mem_addr[1:0] != 2'b00);
            w_be_in      = 4'b1111;
            w_wdata_in   = mem_wdata;
         end
         2'd1: begin
            w_misaligned = mem_addr[0];
            w_be_in      = mem_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_in   = {2{mem_wdata[15:0]}};
         end
         2'd2: begin
            w_be_in      = 4'b0001 << mem_addr[1:0];
            w_wdata_in   = {4{mem_wdata[7:0]}};
         end
         default: begin
            w_misaligned = 1'b0;
         end
      endcase
   end

   // Select the addressed lane of the returned word and zero/sign-extend it.
   always_comb begin
      w_shifted   = bus_rdata >> {r_lane, 3'b000};
      w_half      = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      w_load_data = 32'd0;
      case (r_width)
         2'd0:    w_load_data = bus_rdata;
         2'd1:    w_load_data = {{16{r_sign & w_half[15]}}, w_half};
         2'd2:    w_load_data = {{24{r_sign & w_shifted[7]}}, w_shifted[7:0]};
         default: w_load_data = 32'd0;
      endcase
   end

   // Request FSM; every bus and completion output is a register updated here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_width     <= 2'd0;
         r_sign      <= 1'b0;
         r_lane      <= 2'd0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'd0;
         r_bus_be    <= 4'b0000;
         r_bus_wdata <= 32'd0;
         r_mem_done  <= 1'b0;
         r_mem_rdata <= 32'd0;
         r_mem_exc   <= EXC_NONE;
`ifdef MEM_TIMEOUT_EN
         r_tmo_cnt   <= '0;
`endif
      end else begin
         r_mem_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (mem_valid) begin
                  if (mem_width == 2'd3) begin
                     // Reserved width completes quietly without touching the bus.
                     r_state     <= ST_DONE;
                     r_mem_done  <= 1'b1;
                     r_mem_exc   <= EXC_NONE;
                     r_mem_rdata <= 32'd0;
                  end else if (w_misaligned) begin
                     r_state     <= ST_DONE;
                     r_mem_done  <= 1'b1;
                     r_mem_exc   <= mem_we ? EXC_ST_ALIGN : EXC_LD_ALIGN;
                     r_mem_rdata <= 32'd0;
                  end else begin
                     r_state     <= ST_REQ;
                     r_width     <= mem_width;
                     r_sign      <= mem_sign;
                     r_lane      <= mem_addr[1:0];
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= mem_we;
                     r_bus_addr  <= {mem_addr[31:2], 2'b00};
                     r_bus_be    <= w_be_in;
                     r_bus_wdata <= w_wdata_in;
`ifdef MEM_TIMEOUT_EN
                     r_tmo_cnt   <= '0;
`endif
                  end
               end
            end
            ST_REQ: begin
               if (bus_ack) begin
                  r_state     <= ST_DONE;
                  r_mem_done  <= 1'b1;
                  r_mem_exc   <= EXC_NONE;
                  r_mem_rdata <= r_bus_we ? 32'd0 : w_load_data;
                  r_bus_req   <= 1'b0;
                  r_bus_we    <= 1'b0;
                  r_bus_be    <= 4'b0000;
               end
`ifdef MEM_TIMEOUT_EN
               else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_state     <= ST_DONE;
                  r_mem_done  <= 1'b1;
                  r_mem_exc   <= 2'd3;
                  r_mem_rdata <= 32'd0;
                  r_bus_req   <= 1'b0;
                  r_bus_we    <= 1'b0;
                  r_bus_be    <= 4'b0000;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_stall = mem_valid & ~r_mem_done;
   assign mem_done  = r_mem_done;
   assign mem_rdata = r_mem_rdata;
   assign mem_exc   = r_mem_exc;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_be    = r_bus_be;
   assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_req_unit.sv
// Testbench for mem_req_unit: directed vector table, randomized transactions
// against a behavioural model, and hand-written reset / ack-ignore sequences.
module tb_mem_req_unit;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic        mem_we;
   logic [1:0]  mem_width;
   logic        mem_sign;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_stall;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_exc;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] last_rdata = 32'd0;
   logic [1:0]  last_exc   = 2'd0;

   typedef struct {
      logic        we;
      logic [1:0]  width;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic        exp_bus;
      logic [3:0]  exp_be;
      logic [31:0] exp_bwdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_exc;
   } vec_t;

   vec_t tbl[8];

   mem_req_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_width(mem_width),
      .mem_sign(mem_sign), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .mem_exc(mem_exc), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model from the access rules: size in bytes, alignment by
   // modulo, lane select by shift/mask, replication by multiplication.
   function automatic vec_t model(input logic we, input logic [1:0] width, input logic sign,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int delay);
      vec_t   v;
      int     nbytes;
      longint val;
      longint mask;
      v.we = we; v.width = width; v.sign = sign; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.delay = delay;
      v.exp_bus = 1'b0; v.exp_be = 4'd0; v.exp_bwdata = 32'd0;
      v.exp_rdata = 32'd0; v.exp_exc = 2'd0;
      if (width == 2'd3) return v;
      nbytes = (width == 2'd0) ? 4 : (width == 2'd1) ? 2 : 1;
      if ((addr % nbytes) != 0) begin
         v.exp_exc = we ? 2'd2 : 2'd1;
         return v;
      end
      v.exp_bus = 1'b1;
      v.exp_be  = 4'(((1 << nbytes) - 1) << (addr % 4));
      mask = (longint'(1) << (8 * nbytes)) - 1;
      if (nbytes == 4)      v.exp_bwdata = wdata;
      else if (nbytes == 2) v.exp_bwdata = 32'((longint'(wdata) & mask) * 32'h0001_0001);
      else                  v.exp_bwdata = 32'((longint'(wdata) & mask) * 32'h0101_0101);
      if (!we) begin
         val = (longint'(rdata) >> (8 * (addr % 4))) & mask;
         if (sign && nbytes < 4 && val >= ((mask + 1) / 2)) val = val - (mask + 1);
         v.exp_rdata = 32'(val);
      end
      return v;
   endfunction

   // One pipeline transaction, entered and left at a falling edge.
   task automatic run_txn(input vec_t v, input string tag);
      chk({tag, " rdata_hold"}, mem_rdata, last_rdata);
      chk({tag, " exc_hold"}, 32'(mem_exc), 32'(last_exc));
      mem_we = v.we; mem_width = v.width; mem_sign = v.sign;
      mem_addr = v.addr; mem_wdata = v.wdata; mem_valid = 1'b1;
      bus_ack = 1'b0; bus_rdata = $urandom;
      #1 chk({tag, " stall_accept"}, 32'(mem_stall), 32'd1);
      @(negedge clk);
      if (v.exp_bus) begin
         chk({tag, " bus_req"}, 32'(bus_req), 32'd1);
         chk({tag, " bus_we"}, 32'(bus_we), 32'(v.we));
         chk({tag, " bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
         chk({tag, " bus_be"}, 32'(bus_be), 32'(v.exp_be));
         chk({tag, " bus_wdata"}, bus_wdata, v.exp_bwdata);
         for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            chk({tag, " wait_req"}, 32'(bus_req), 32'd1);
            chk({tag, " wait_be"}, 32'(bus_be), 32'(v.exp_be));
            chk({tag, " wait_wdata"}, bus_wdata, v.exp_bwdata);
            chk({tag, " wait_stall"}, 32'(mem_stall), 32'd1);
            chk({tag, " wait_done"}, 32'(mem_done), 32'd0);
         end
         bus_rdata = v.rdata;
         bus_ack   = 1'b1;
         @(negedge clk);
         bus_ack   = 1'b0;
      end
      chk({tag, " done"}, 32'(mem_done), 32'd1);
      chk({tag, " exc"}, 32'(mem_exc), 32'(v.exp_exc));
      chk({tag, " rdata"}, mem_rdata, v.exp_rdata);
      chk({tag, " req_off"}, 32'(bus_req), 32'd0);
      chk({tag, " be_off"}, 32'(bus_be), 32'd0);
      chk({tag, " stall_done"}, 32'(mem_stall), 32'd0);
      mem_valid  = 1'b0;
      last_rdata = v.exp_rdata;
      last_exc   = v.exp_exc;
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(mem_done), 32'd0);
      $display("txn %s we=%0d w=%0d addr=%h rdata=%h exc=%0d", tag, v.we, v.width,
               v.addr, mem_rdata, mem_exc);
   endtask

   initial begin
      vec_t v;
      reset = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_width = 2'd0;
      mem_sign = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
      bus_ack = 1'b0; bus_rdata = 32'd0;

      // Directed vectors: {we,width,sign,addr,wdata,rdata,delay, bus,be,bwdata,rdata,exc}
      tbl[0] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 0,
                 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 2'd0};
      tbl[1] = '{1'b0, 2'd2, 1'b1, 32'h7, 32'h000000A5, 32'h80FFFFFF, 0,
                 1'b1, 4'b1000, 32'hA5A5A5A5, 32'hFFFFFF80, 2'd0};
      tbl[2] = '{1'b0, 2'd2, 1'b0, 32'h7, 32'h000000A5, 32'h80FFFFFF, 1,
                 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h00000080, 2'd0};
      tbl[3] = '{1'b0, 2'd0, 1'b0, 32'h6, 32'h0, 32'h0, 0,
                 1'b0, 4'b0000, 32'h0, 32'h0, 2'd1};
      tbl[4] = '{1'b1, 2'd0, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 5,
                 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 2'd0};
      tbl[5] = '{1'b0, 2'd3, 1'b1, 32'h13, 32'h0, 32'h0, 0,
                 1'b0, 4'b0000, 32'h0, 32'h0, 2'd0};
      tbl[6] = '{1'b1, 2'd1, 1'b0, 32'h1, 32'h5555, 32'h0, 0,
                 1'b0, 4'b0000, 32'h0, 32'h0, 2'd2};
      tbl[7] = '{1'b0, 2'd1, 1'b1, 32'h42, 32'h00007777, 32'h80011234, 2,
                 1'b1, 4'b1100, 32'h77777777, 32'hFFFF8001, 2'd0};

      // Reset state
      #2;
      chk("rst bus_req", 32'(bus_req), 32'd0);
      chk("rst bus_be", 32'(bus_be), 32'd0);
      chk("rst bus_addr", bus_addr, 32'd0);
      chk("rst bus_wdata", bus_wdata, 32'd0);
      chk("rst mem_done", 32'(mem_done), 32'd0);
      chk("rst mem_exc", 32'(mem_exc), 32'd0);
      chk("rst mem_rdata", mem_rdata, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // bus_ack while idle must not start or finish anything
      bus_ack = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("idle_ack done", 32'(mem_done), 32'd0);
      chk("idle_ack req", 32'(bus_req), 32'd0);
      chk("idle_ack rdata", mem_rdata, last_rdata);
      bus_ack = 1'b0;
      @(negedge clk);

      // Randomized transactions against the model
      for (int i = 0; i < 150; i++) begin
         v = model(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
         run_txn(v, $sformatf("rnd%0d", i));
      end

      // Reset pulsed mid-request: bus_req drops at once, no completion follows
      mem_we = 1'b1; mem_width = 2'd0; mem_sign = 1'b0;
      mem_addr = 32'h40; mem_wdata = 32'h0BADF00D; mem_valid = 1'b1;
      @(negedge clk);
      chk("midrst req_before", 32'(bus_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("midrst req_async", 32'(bus_req), 32'd0);
      chk("midrst be_async", 32'(bus_be), 32'd0);
      chk("midrst addr_async", bus_addr, 32'd0);
      mem_valid = 1'b0;
      bus_ack = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst no_done", 32'(mem_done), 32'd0);
         chk("midrst no_req", 32'(bus_req), 32'd0);
      end
      bus_ack = 1'b0;
      last_rdata = 32'd0;
      last_exc   = 2'd0;
      $display("txn midrst reset during REQ discarded");

`ifdef MEM_TIMEOUT_EN
      // No ack: four request cycles then a timeout completion
      mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h80; mem_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tmo req", 32'(bus_req), 32'd1);
         chk("tmo not_done", 32'(mem_done), 32'd0);
      end
      @(negedge clk);
      chk("tmo done", 32'(mem_done), 32'd1);
      chk("tmo exc", 32'(mem_exc), 32'd3);
      chk("tmo rdata", mem_rdata, 32'd0);
      chk("tmo req_off", 32'(bus_req), 32'd0);
      mem_valid = 1'b0;
      @(negedge clk);
      $display("txn tmo timeout exc=%0d", mem_exc);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
